// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: shadow EX/MEM control bits, data-hazard
// detection, branch flush, and a timed ready handshake for multi-cycle data-memory accesses.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rf_we,
  input  logic [3:0]  id_dst_addr,
  input  logic [3:0]  id_src1_addr,
  input  logic [3:0]  id_src2_addr,
  input  logic        id_src1_used,
  input  logic        id_src2_used,
  input  logic        id_dm_re,
  input  logic        id_dm_we,
  input  logic        branch_taken,
  input  logic        dm_rdy,
  output logic        stall_if_id,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic        freeze,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam logic [7:0] TmoMax = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWait, StAbort} state_e;

  state_e     state_q;
  logic [7:0] tmo_cnt_q;

  logic       ex_vld_q, ex_rf_we_q, ex_dm_re_q, ex_dm_we_q;
  logic [3:0] ex_dst_q;
  logic       mem_vld_q, mem_rf_we_q, mem_dm_re_q, mem_dm_we_q;
  logic [3:0] mem_dst_q;

  logic match1, match2, haz, mem_acc;
  logic freeze_c, flush_c, stall_c, bubble_c;

  always_comb begin
    match1   = (ex_vld_q & ex_rf_we_q & (ex_dst_q == id_src1_addr)) |
               (mem_vld_q & mem_rf_we_q & (mem_dst_q == id_src1_addr));
    match2   = (ex_vld_q & ex_rf_we_q & (ex_dst_q == id_src2_addr)) |
               (mem_vld_q & mem_rf_we_q & (mem_dst_q == id_src2_addr));
    haz      = id_valid & ((id_src1_used & match1) | (id_src2_used & match2));
    mem_acc  = mem_vld_q & (mem_dm_re_q | mem_dm_we_q);
    // The cycle dm_rdy arrives completes the access, so WAIT only freezes while still unready.
    freeze_c = ~dm_rdy & (((state_q == StIdle) & mem_acc) | (state_q == StWait));
    flush_c  = ~freeze_c & branch_taken;
    stall_c  = ~freeze_c & ~branch_taken & haz;
    bubble_c = flush_c | stall_c;
  end

  // Held at zero while reset is asserted, independent of the live inputs.
  always_comb begin
    freeze       = ~rst & freeze_c;
    flush_if_id  = ~rst & flush_c;
    stall_if_id  = ~rst & stall_c;
    bubble_id_ex = ~rst & bubble_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= 8'd0;
      mem_err     <= 1'b0;
      stall_cnt   <= 16'd0;
      ex_vld_q    <= 1'b0;
      ex_rf_we_q  <= 1'b0;
      ex_dst_q    <= 4'd0;
      ex_dm_re_q  <= 1'b0;
      ex_dm_we_q  <= 1'b0;
      mem_vld_q   <= 1'b0;
      mem_rf_we_q <= 1'b0;
      mem_dst_q   <= 4'd0;
      mem_dm_re_q <= 1'b0;
      mem_dm_we_q <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_acc & ~dm_rdy) begin
            state_q   <= StWait;
            tmo_cnt_q <= 8'd1;
          end
        end
        StWait: begin
          if (dm_rdy) begin
            state_q   <= StIdle;
            tmo_cnt_q <= 8'd0;
          end else if (tmo_cnt_q == TmoMax) begin
            state_q <= StAbort;
            mem_err <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StAbort: begin
          state_q   <= StIdle;
          tmo_cnt_q <= 8'd0;
        end
        default: begin
          state_q   <= StIdle;
          tmo_cnt_q <= 8'd0;
        end
      endcase

      // An aborted access leaves MEM here too: ABORT never freezes, so MEM is overwritten by EX.
      if (!freeze_c) begin
        mem_vld_q   <= ex_vld_q;
        mem_rf_we_q <= ex_rf_we_q;
        mem_dst_q   <= ex_dst_q;
        mem_dm_re_q <= ex_dm_re_q;
        mem_dm_we_q <= ex_dm_we_q;
        if (bubble_c | ~id_valid) begin
          ex_vld_q   <= 1'b0;
          ex_rf_we_q <= 1'b0;
          ex_dst_q   <= 4'd0;
          ex_dm_re_q <= 1'b0;
          ex_dm_we_q <= 1'b0;
        end else begin
          ex_vld_q   <= 1'b1;
          ex_rf_we_q <= id_rf_we;
          ex_dst_q   <= id_dst_addr;
          ex_dm_re_q <= id_dm_re;
          ex_dm_we_q <= id_dm_we;
        end
      end

      if ((freeze_c | stall_c) && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios against hand-derived values, then
// randomized traffic against a slot-and-age reference model.
module tb_hazard_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rf_we, id_src1_used, id_src2_used, id_dm_re, id_dm_we;
  logic [3:0]  id_dst_addr, id_src1_addr, id_src2_addr;
  logic        branch_taken, dm_rdy;
  logic        stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rf_we     (id_rf_we),
    .id_dst_addr  (id_dst_addr),
    .id_src1_addr (id_src1_addr),
    .id_src2_addr (id_src2_addr),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dm_re     (id_dm_re),
    .id_dm_we     (id_dm_we),
    .branch_taken (branch_taken),
    .dm_rdy       (dm_rdy),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .freeze       (freeze),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  // Reference model: an instruction slot for EX and MEM, plus how long MEM has been stuck.
  typedef struct packed {
    logic       vld;
    logic       rf_we;
    logic [3:0] dst;
    logic       dm_re;
    logic       dm_we;
  } slot_t;

  slot_t m_ex, m_mem;
  int    m_age;
  bit    m_abort;
  bit    m_err;
  int    m_cnt;
  logic  e_stall, e_bubble, e_flush, e_freeze;

  int checks = 0;
  int failures = 0;

  function automatic bit hits(slot_t s, logic [3:0] a);
    return s.vld && s.rf_we && (s.dst == a);
  endfunction

  function void eval();
    bit haz, acc;
    haz = id_valid &&
          ((id_src1_used && (hits(m_ex, id_src1_addr) || hits(m_mem, id_src1_addr))) ||
           (id_src2_used && (hits(m_ex, id_src2_addr) || hits(m_mem, id_src2_addr))));
    acc      = m_mem.vld && (m_mem.dm_re || m_mem.dm_we);
    e_freeze = !m_abort && acc && !dm_rdy;
    e_flush  = !e_freeze && branch_taken;
    e_stall  = !e_freeze && !branch_taken && haz;
    e_bubble = e_flush || e_stall;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_age = 0; m_abort = 0; m_err = 0; m_cnt = 0;
  endtask

  // One clock: model advances with the inputs seen before the edge; returns at edge + 1.
  task automatic tick();
    eval();
    @(posedge clk);
    if (e_freeze) begin
      m_age++;
      m_abort = (m_age == int'(T) + 1);
    end else begin
      m_mem = m_ex;
      if (e_bubble || !id_valid) m_ex = '0;
      else begin
        m_ex.vld = 1'b1; m_ex.rf_we = id_rf_we; m_ex.dst = id_dst_addr;
        m_ex.dm_re = id_dm_re; m_ex.dm_we = id_dm_we;
      end
      m_age = 0;
      m_abort = 0;
    end
    m_err = m_abort;
    if ((e_freeze || e_stall) && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  task automatic set_id(input bit v, input bit we, input logic [3:0] dst,
                        input logic [3:0] s1, input bit u1, input logic [3:0] s2, input bit u2,
                        input bit re, input bit wr);
    id_valid = v; id_rf_we = we; id_dst_addr = dst;
    id_src1_addr = s1; id_src1_used = u1; id_src2_addr = s2; id_src2_used = u2;
    id_dm_re = re; id_dm_we = wr;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0;
    dm_rdy = 1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1, 1, 4'd2, 4'd2, 1, 4'd2, 1, 1, 0);
    branch_taken = 1;
    dm_rdy = 0;
    model_reset();
    #13;
    checks++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err, stall_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%0d want=all zero",
               stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0;
    dm_rdy = 1;
  endtask

  task automatic test_dist1();
    set_id(1, 1, 4'd4, 4'd0, 0, 4'd0, 0, 0, 0);
    tick();
    set_id(1, 0, 4'd0, 4'd4, 1, 4'd1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({stall_if_id, bubble_id_ex} !== {2{i < 2}}) begin
        failures++;
        $display("FAIL dist1_stall cyc%0d got=%b%b want=%b", i, stall_if_id, bubble_id_ex,
                 {2{i < 2}});
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd2) begin
      failures++;
      $display("FAIL dist1_stall_cnt got=%0d want=2", stall_cnt);
    end
  endtask

  task automatic test_dist2();
    for (int pass = 0; pass < 2; pass++) begin
      set_id(1, 1, 4'd7, 4'd0, 0, 4'd0, 0, 0, 0);
      tick();
      set_id(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);
      tick();
      set_id(1, 0, 4'd0, 4'd3, 1, 4'd7, pass == 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        #2;
        checks++;
        if (stall_if_id !== (pass == 0 && i == 0)) begin
          failures++;
          $display("FAIL dist2_stall pass%0d cyc%0d got=%b want=%b", pass, i, stall_if_id,
                   (pass == 0 && i == 0));
        end
        tick();
      end
    end
  endtask

  task automatic test_mem_wait();
    drain();
    set_id(1, 1, 4'd9, 4'd0, 0, 4'd0, 0, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // Reader of r9 in ID: suppressed while frozen, then stalls because MEM still holds the load.
    set_id(1, 0, 4'd0, 4'd9, 1, 4'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      dm_rdy = (i == 3);
      #2;
      checks++;
      if ({freeze, stall_if_id, flush_if_id} !== {i < 3, i == 3, 1'b0}) begin
        failures++;
        $display("FAIL mem_wait cyc%0d got frz/stl/fl=%b%b%b want=%b%b0", i, freeze,
                 stall_if_id, flush_if_id, i < 3, i == 3);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      drain();
      set_id(1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      // pass 0: ready never comes; pass 1: ready lands on the last allowed cycle.
      for (int i = 0; i < int'(T) + 3; i++) begin
        bit want_frz, want_err;
        dm_rdy = (pass == 1) && (i == int'(T));
        want_frz = (pass == 0) ? (i <= int'(T)) : (i < int'(T));
        want_err = (pass == 0) && (i == int'(T) + 1);
        #2;
        checks++;
        if ({freeze, mem_err} !== {want_frz, want_err}) begin
          failures++;
          $display("FAIL timeout pass%0d cyc%0d got frz/err=%b%b want=%b%b", pass, i,
                   freeze, mem_err, want_frz, want_err);
        end
        tick();
      end
    end
  endtask

  task automatic test_priority();
    drain();
    set_id(1, 1, 4'd4, 4'd0, 0, 4'd0, 0, 0, 0);
    tick();
    set_id(1, 0, 4'd0, 4'd4, 1, 4'd0, 0, 0, 0);
    branch_taken = 1;
    #2;
    checks++;
    if ({flush_if_id, bubble_id_ex, stall_if_id} !== 3'b110) begin
      failures++;
      $display("FAIL prio_branch_haz got fl/bub/stl=%b%b%b want=110", flush_if_id,
               bubble_id_ex, stall_if_id);
    end
    tick();
    drain();
    set_id(1, 1, 4'd5, 4'd0, 0, 4'd0, 0, 1, 0);
    tick();
    set_id(1, 0, 4'd0, 4'd1, 1, 4'd0, 0, 0, 0);
    tick();
    branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      dm_rdy = (i == 2);
      #2;
      checks++;
      if ({freeze, flush_if_id, bubble_id_ex} !== {i < 2, i == 2, i == 2}) begin
        failures++;
        $display("FAIL prio_frozen_branch cyc%0d got frz/fl/bub=%b%b%b want=%b%b%b", i,
                 freeze, flush_if_id, bubble_id_ex, i < 2, i == 2, i == 2);
      end
      tick();
    end
    branch_taken = 0;
  endtask

  task automatic test_reset_mid_wait();
    drain();
    set_id(1, 1, 4'd6, 4'd0, 0, 4'd0, 0, 1, 0);
    tick();
    set_id(1, 0, 4'd0, 4'd6, 1, 4'd0, 0, 0, 0);
    tick();
    dm_rdy = 0;
    tick();
    tick();
    branch_taken = 1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err, stall_cnt} !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_wait got=%b/%b/%b/%b/%b/%0d want=all zero",
               stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err, stall_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({freeze, mem_err} !== 2'b00) begin
        failures++;
        $display("FAIL reset_release cyc%0d got frz/err=%b%b want=00", i, freeze, mem_err);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), $urandom_range(0, 1) != 0, 4'($urandom_range(0, 3)),
             $urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      dm_rdy = ($urandom_range(0, 9) < 6);
      #2;
      eval();
      checks++;
      if ({stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err} !==
          {e_stall, e_bubble, e_flush, e_freeze, m_err}) begin
        failures++;
        $display("FAIL rand_ctl cyc%0d got stl/bub/fl/frz/err=%b%b%b%b%b want=%b%b%b%b%b", i,
                 stall_if_id, bubble_id_ex, flush_if_id, freeze, mem_err,
                 e_stall, e_bubble, e_flush, e_freeze, m_err);
      end
      checks++;
      if (stall_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rand_stall_cnt cyc%0d got=%0d want=%0d", i, stall_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dist1();
    test_dist2();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
